spi_master_rx: RTL and testbench

//  SPI master-side receiver for the pattern-generator link. Kicks the slave transmitter (start_tx), drives SCLK,

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sclk_divider.sv | 29 ++
 rtl/spi_master_rx.sv | 140 ++++++++++++++
 tb/tb_spi_master_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master receiver.
package spi_pkg;

  localparam int SPI_WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    LEAD,
    HIGH,
    LOW,
    DONE
  } spi_rx_state_t;

endpackage

// File: rtl/spi_sclk_divider.sv
// Half-period timer for SCLK: phase_end pulses in the last cycle of every CLK_DIV-cycle phase.
module spi_sclk_divider #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase_end
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Holding the counter at zero while disabled makes every enable rise start a full phase.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign phase_end = enable && (cnt == LAST);

endmodule

// File: rtl/spi_master_rx.sv
// SPI master receiver: kicks the slave, clocks out WORD_W+DUMMY SCLK pulses and assembles one word.
// Optional build macro SPI_RX_MISO_SYNC_EN inserts a 2-flop MISO synchronizer.
module spi_master_rx
  import spi_pkg::*;
#(
  parameter int WORD_W  = SPI_WORD_W,
  parameter int CLK_DIV = 8,
  parameter int DUMMY   = 1,
  parameter int GAP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  output logic              start_tx,
  output logic              sclk,
  input  logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  output spi_rx_state_t     state_dbg
);

  localparam int NP = WORD_W + DUMMY;
  localparam int PW = $clog2(NP + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  if (CLK_DIV < 4) begin : g_div_check
    $error("spi_master_rx: CLK_DIV must be at least 4");
  end

  spi_rx_state_t     state;
  logic              phase_end;
  logic              div_en;
  logic              miso_s;
  logic [PW-1:0]     pulse_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [GW-1:0]     gap_cnt;

`ifdef SPI_RX_MISO_SYNC_EN
  logic [1:0] miso_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sync <= '0;
    end else begin
      miso_sync <= {miso_sync[0], miso};
    end
  end

  assign miso_s = miso_sync[1];
`else
  assign miso_s = miso;
`endif

  assign div_en    = (state == LEAD) || (state == HIGH) || (state == LOW);
  assign state_dbg = state;

  spi_sclk_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .enable   (div_en),
    .phase_end(phase_end)
  );

  // Handshake: start is taken only in a cycle where ready is high; a start seen
  // while ready is low is dropped, never queued. ready stays low from KICK through
  // DONE and for GAP idle cycles afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sclk      <= 1'b0;
      start_tx  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      ready     <= 1'b1;
      pulse_cnt <= '0;
      shift_reg <= '0;
      gap_cnt   <= '0;
    end else begin
      start_tx <= 1'b0;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
            ready   <= (gap_cnt == GW'(1));
          end else if (start && ready) begin
            state     <= KICK;
            start_tx  <= 1'b1;
            ready     <= 1'b0;
            pulse_cnt <= '0;
          end
        end
        KICK: begin
          state <= LEAD;
        end
        LEAD: begin
          if (phase_end) begin
            state <= HIGH;
            sclk  <= 1'b1;
          end
        end
        HIGH: begin
          // Sample on the last HIGH cycle: the slave only moves on the coming fall.
          if (phase_end) begin
            state <= LOW;
            sclk  <= 1'b0;
            if (pulse_cnt >= PW'(DUMMY)) begin
              shift_reg <= {shift_reg[WORD_W-2:0], miso_s};
            end
          end
        end
        LOW: begin
          if (phase_end) begin
            if (pulse_cnt < PW'(NP - 1)) begin
              state     <= HIGH;
              sclk      <= 1'b1;
              pulse_cnt <= pulse_cnt + PW'(1);
            end else begin
              state    <= DONE;
              rx_valid <= 1'b1;
              rx_data  <= shift_reg;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          gap_cnt <= GW'(GAP);
          ready   <= (GAP == 0);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_rx.sv
// Directed and randomized bench for spi_master_rx with a behavioural SPI slave and word scoreboard.
module tb_spi_master_rx;
  import spi_pkg::*;

  localparam int WORD_W  = 16;
  localparam int CLK_DIV = 8;
  localparam int DUMMY   = 1;
  localparam int GAP     = 4;
  localparam int NP      = WORD_W + DUMMY;
  localparam int LAT     = 1 + CLK_DIV * (2 * NP + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              miso = 1'b0;
  logic              ready;
  logic              start_tx;
  logic              sclk;
  logic              rx_valid;
  logic [WORD_W-1:0] rx_data;
  spi_rx_state_t     state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [WORD_W-1:0] exp_q[$];
  logic [WORD_W-1:0] slave_q[$];

  spi_master_rx #(
    .WORD_W (WORD_W),
    .CLK_DIV(CLK_DIV),
    .DUMMY  (DUMMY),
    .GAP    (GAP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ready    (ready),
    .start_tx (start_tx),
    .sclk     (sclk),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // slave model, protocol monitor and scoreboard, all sampled on the falling clk edge
  int kick_cnt = 0, valid_cnt = 0, rises = 0, hi_cnt = 0;
  int kick_cyc = -1, last_valid_cyc = -1, sl_falls = 0;
  logic sclk_q = 1'b0, valid_q = 1'b0;
  logic [WORD_W-1:0] sl_word = '0;

  always @(negedge clk) begin
    if (reset) begin
      rises = 0; hi_cnt = 0; sclk_q = 1'b0; valid_q = 1'b0;
      kick_cyc = -1; last_valid_cyc = -1; sl_falls = 0; sl_word = '0;
      exp_q.delete();
    end else begin
      if (start_tx || sclk || rx_valid) check("ready_low_when_busy", ready, 0);
      if (start_tx) begin
        kick_cnt++;
        if (last_valid_cyc >= 0) check("gap_idle_cycles", ((cyc - last_valid_cyc - 1) >= GAP), 1);
        kick_cyc = cyc;
        rises = 0;
        hi_cnt = 0;
        if (slave_q.size() > 0) sl_word = slave_q.pop_front();
        else sl_word = WORD_W'($urandom);
        exp_q.push_back(sl_word);
        sl_falls = 0;
      end
      if (sclk && !sclk_q) rises++;
      if (sclk) hi_cnt++;
      if (!sclk && sclk_q) begin
        check("sclk_high_width", hi_cnt, CLK_DIV);
        hi_cnt = 0;
        if (sl_falls > 0) sl_word = sl_word << 1;
        sl_falls++;
      end
      if (rx_valid) begin
        valid_cnt++;
        check("rx_valid_width", valid_q, 0);
        check("sclk_pulse_count", rises, NP);
        check("rx_valid_latency", cyc - kick_cyc, LAT);
        check("valid_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("rx_data", rx_data, exp_q.pop_front());
        last_valid_cyc = cyc;
      end
      sclk_q  = sclk;
      valid_q = rx_valid;
    end
    miso = sl_word[WORD_W-1];
  end

  // driver tasks
  task automatic pulse_start();
    int guard = 0;
    while (!ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", ready, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valids(input int target, input int bound);
    int guard = 0;
    while (valid_cnt < target && guard < bound) begin
      @(negedge clk);
      guard++;
    end
    check("valid_count", valid_cnt, target);
  endtask

  task automatic wait_rises(input int target);
    int guard = 0;
    while (!(rises == target && sclk) && guard < LAT + 50) begin
      @(negedge clk);
      guard++;
    end
    check("reached_pulse", rises, target);
  endtask

  initial begin
    int k0;
    int v0;
    int guard;
    logic [WORD_W-1:0] w;

    // reset state, and reset winning over a simultaneous start
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_sclk", sclk, 0);
    check("reset_start_tx", start_tx, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_ready", ready, 1);
    check("reset_state", state_dbg, IDLE);
    start = 1'b1;
    @(negedge clk);
    check("reset_beats_start", start_tx, 0);
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single transfer of 0xA5C3
    slave_q.push_back(16'hA5C3);
    k0 = kick_cnt;
    v0 = valid_cnt;
    pulse_start();
    wait_valids(v0 + 1, LAT + 50);
    check("t1_rx_data", rx_data, 16'hA5C3);
    repeat (GAP + 10) @(negedge clk);
    check("t1_one_kick", kick_cnt, k0 + 1);
    check("t1_rx_data_hold", rx_data, 16'hA5C3);

    // three words with start held high
    slave_q.push_back(16'h0000);
    slave_q.push_back(16'hFFFF);
    slave_q.push_back(16'h8001);
    k0 = kick_cnt;
    v0 = valid_cnt;
    start = 1'b1;
    guard = 0;
    while (kick_cnt < k0 + 3 && guard < 3 * (LAT + GAP + 20)) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    wait_valids(v0 + 3, LAT + 50);
    check("t2_last_word", rx_data, 16'h8001);
    repeat (GAP + 20) @(negedge clk);
    check("t2_kicks", kick_cnt, k0 + 3);
    check("t2_valids", valid_cnt, v0 + 3);

    // start pulsed during HIGH of pulse 5 is ignored
    slave_q.push_back(WORD_W'($urandom));
    k0 = kick_cnt;
    v0 = valid_cnt;
    pulse_start();
    wait_rises(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valids(v0 + 1, LAT + 50);
    repeat (GAP + 10) @(negedge clk);
    check("t3_kicks", kick_cnt, k0 + 1);
    check("t3_valids", valid_cnt, v0 + 1);

    // reset during pulse 9 aborts the word, then 0x1234
    slave_q.push_back(WORD_W'($urandom));
    pulse_start();
    wait_rises(10);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sclk", sclk, 0);
    check("abort_rx_data", rx_data, 0);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_ready", ready, 1);
    check("abort_state", state_dbg, IDLE);
    @(negedge clk);
    reset = 1'b0;
    v0 = valid_cnt;
    repeat (LAT + 20) @(negedge clk);
    check("abort_no_valid", valid_cnt, v0);
    slave_q.push_back(16'h1234);
    pulse_start();
    wait_valids(v0 + 1, LAT + 50);
    check("t4_rx_data", rx_data, 16'h1234);

    // randomized words with random idle spacing
    for (int i = 0; i < 6; i++) begin
      w = WORD_W'($urandom);
      slave_q.push_back(w);
      v0 = valid_cnt;
      repeat ($urandom_range(0, 10)) @(negedge clk);
      pulse_start();
      wait_valids(v0 + 1, LAT + 50);
      check("rand_rx_data", rx_data, w);
    end

    repeat (GAP + 10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
